// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//
// Oversampled UART receiver. The serial line is synchronized into the
// baud_clk domain and a six-state FSM samples the middle of every bit.
// Results are reported through registered single-cycle pulses.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  baud_clk cycles per bit (even, >= 8)
//   PARITY_EN   1: one parity bit follows the data bits
//   PARITY_ODD  1: odd parity, 0: even parity (only used when PARITY_EN=1)
//
// Ports
//   baud_clk       in   oversample clock, all logic on its rising edge
//   rst            in   synchronous active-high reset
//   rx_in          in   asynchronous serial line, idles high, LSB first
//   data_out       out  last correctly framed word, held between frames
//   data_valid     out  one-cycle pulse, data_out has just been updated
//   parity_error   out  one-cycle pulse with data_valid on parity mismatch
//   framing_error  out  one-cycle pulse when the stop bit is sampled low
//   busy           out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // Parity bit the transmitter should have sent for the given data word.
    function automatic logic f_expected_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Registered state
    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pflag;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;

    // Next-state values
    logic                 w_rx_s;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_pflag_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_perr_nxt;
    logic                 w_ferr_nxt;

    assign w_rx_s = r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        // Free-running 0..OVERSAMPLE-1 inside a state; transitions force 0.
        w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pflag_nxt = r_pflag;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_perr_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_pflag_nxt = 1'b0;
                end
            end

            START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            DATA: begin
                // Counting from mid start bit, cnt=LAST lands on mid data bit.
                if (r_cnt == CNT_LAST) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_pflag_nxt = (w_rx_s != f_expected_parity(r_shift));
                    w_state_nxt = STOP;
                end
            end

            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_perr_nxt  = r_pflag;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // Hold here through a break so it yields only one pulse.
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_pflag <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_pflag <= w_pflag_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    assign data_out      = r_data;
    assign data_valid    = r_valid;
    assign parity_error  = r_perr;
    assign framing_error = r_ferr;
    assign busy          = (r_state != IDLE);

endmodule
